// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-Stream slave to UART transmitter.
// Takes one byte per AXIS handshake and sends it on TX as a UART frame:
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   aclk       clock, rising edge
//   aresetn    asynchronous active-low reset
//   in_tdata   byte to transmit (bits above DATA_BITS ignored)
//   in_tvalid  AXIS valid
//   in_tready  AXIS ready, high only while idle
//   TX         UART serial line, idle high
//   busy       high from handshake until the frame is done
module axis_uart_tx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  output logic       TX,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = 3;

  // Parameter legality, reported at elaboration.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("axis_uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("axis_uart_tx: DATA_BITS must be 5..8");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("axis_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("axis_uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_bit;
  logic                   baud_wrap_c;
  logic                   par_calc_c;
  logic                   unused_tdata;

  // Upper in_tdata bits are intentionally dropped for narrow frames.
  assign unused_tdata = ^in_tdata;

  assign baud_wrap_c = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  assign par_calc_c = (^in_tdata[DATA_BITS-1:0]) ^ (PARITY == 1);

  // Frame FSM. TX is registered from the current state, so the line
  // follows the state by one clock: TX falls on the edge after the handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      TX        <= 1'b1;
      in_tready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Baud counter runs in every non-idle state and wraps at each bit boundary.
      if (state != S_IDLE) begin
        if (baud_wrap_c) begin
          baud_cnt <= '0;
        end else begin
          baud_cnt <= baud_cnt + CNT_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          TX <= 1'b1;
          if (in_tready && in_tvalid) begin
            shift_reg <= in_tdata[DATA_BITS-1:0];
            par_bit   <= par_calc_c;
            in_tready <= 1'b0;
            busy      <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            state     <= S_START;
          end else begin
            in_tready <= 1'b1;
          end
        end

        S_START: begin
          TX <= 1'b0;
          if (baud_wrap_c) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          TX <= shift_reg[0];
          if (baud_wrap_c) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        S_PARITY: begin
          TX <= par_bit;
          if (baud_wrap_c) begin
            state <= S_STOP;
          end
        end

        S_STOP: begin
          TX <= 1'b1;
          if (baud_wrap_c) begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
              bit_cnt   <= '0;
              in_tready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        default: begin
          TX    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: checks axis_uart_tx in five configurations (10 clk/bit)
// against a frame-timeline model, plus literal expectations for each scenario.
module tb_axis_uart_tx;

  localparam int NI  = 5;
  localparam int CPB = 10;
  // Instances: 0 plain 8N1, 1 even parity, 2 odd parity, 3 two stop bits, 4 seven data bits
  localparam int unsigned D_A [NI] = '{8, 8, 8, 8, 7};
  localparam int unsigned P_A [NI] = '{0, 2, 1, 0, 0};
  localparam int unsigned S_A [NI] = '{1, 1, 1, 2, 1};

  logic       clk;
  logic       rst_n;
  logic       tvalid [NI];
  logic [7:0] tdata  [NI];
  logic       rdy_w  [NI];
  logic       tx_w   [NI];
  logic       busy_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axis_uart_tx #(
      .CLK_FREQ (100_000_000),
      .BAUD_RATE(10_000_000),
      .DATA_BITS(D_A[g]),
      .PARITY   (P_A[g]),
      .STOP_BITS(S_A[g])
    ) u_dut (
      .aclk     (clk),
      .aresetn  (rst_n),
      .in_tdata (tdata[g]),
      .in_tvalid(tvalid[g]),
      .in_tready(rdy_w[g]),
      .TX       (tx_w[g]),
      .busy     (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Model: age = edges since last handshake; frame bits laid out on a timeline.
  int   age   [NI];
  int   flen  [NI];
  logic fb    [NI][16];
  logic m_rdy [NI];
  logic m_busy[NI];
  logic m_tx  [NI];

  logic smp [NI][256];
  int   rise[NI];

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %b, expected %b", name, i, $time, act, exp);
    end
  endtask

  task automatic chkv(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      age[i]    = 1_000_000;
      flen[i]   = 0;
      m_rdy[i]  = 1'b0;
      m_busy[i] = 1'b0;
      m_tx[i]   = 1'b1;
    end
  endtask

  // One clock: advance the model at the rising edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_rdy[i] && tvalid[i]) begin
          int   n;
          logic par;
          n   = 0;
          par = 1'b0;
          fb[i][n] = 1'b0; n++;
          for (int k = 0; k < int'(D_A[i]); k++) begin
            fb[i][n] = tdata[i][k];
            par      = par ^ tdata[i][k];
            n++;
          end
          if (P_A[i] != 0) begin
            fb[i][n] = (P_A[i] == 1) ? ~par : par;
            n++;
          end
          for (int s = 0; s < int'(S_A[i]); s++) begin
            fb[i][n] = 1'b1; n++;
          end
          flen[i]   = n * CPB;
          age[i]    = 0;
          m_rdy[i]  = 1'b0;
          m_busy[i] = 1'b1;
        end else begin
          age[i]++;
          if (!m_rdy[i]) begin
            if (!m_busy[i]) begin
              m_rdy[i] = 1'b1;
            end else if (age[i] == flen[i]) begin
              m_rdy[i]  = 1'b1;
              m_busy[i] = 1'b0;
            end
          end
        end
        m_tx[i] = (age[i] >= 1 && age[i] <= flen[i]) ? fb[i][(age[i] - 1) / CPB] : 1'b1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("tx", i, tx_w[i], m_tx[i]);
      chk("tready", i, rdy_w[i], m_rdy[i]);
      chk("busy", i, busy_w[i], m_busy[i]);
    end
  endtask

  initial begin
    logic [9:0] got10;
    logic [7:0] got8;
    int         first_fall;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tvalid[i] = 1'b0;
      tdata[i]  = 8'h00;
      rise[i]   = -1;
    end
    model_reset();

    // Reset held for 5 cycles, then release.
    repeat (5) cyc();
    chk("rst_tx", 0, tx_w[0], 1'b1);
    chk("rst_tready", 0, rdy_w[0], 1'b0);
    chk("rst_busy", 0, busy_w[0], 1'b0);
    rst_n = 1'b1;
    cyc();
    chk("rel_tready", 0, rdy_w[0], 1'b1);

    // 0xA5 on plain / even / odd instances, 0xFF on the 7-bit instance.
    tvalid[0] = 1'b1; tdata[0] = 8'hA5;
    tvalid[1] = 1'b1; tdata[1] = 8'hA5;
    tvalid[2] = 1'b1; tdata[2] = 8'hA5;
    tvalid[4] = 1'b1; tdata[4] = 8'hFF;
    cyc();
    for (int i = 0; i < NI; i++) begin
      tvalid[i] = 1'b0;
      tdata[i]  = 8'h00;
      rise[i]   = -1;
    end
    chk("e0_tx", 0, tx_w[0], 1'b1);
    chk("e0_tready", 0, rdy_w[0], 1'b0);
    chk("e0_busy", 0, busy_w[0], 1'b1);
    for (int k = 1; k <= 115; k++) begin
      cyc();
      for (int i = 0; i < NI; i++) begin
        smp[i][k] = tx_w[i];
        if (rise[i] < 0 && rdy_w[i]) rise[i] = k;
      end
    end
    for (int b = 0; b < 10; b++) got10[b] = smp[0][10 * b + 5];
    chkv("a5_frame_bits", int'(got10), 32'h34A);
    chkv("a5_ready_rise", rise[0], 100);
    chk("even_parity_bit", 1, smp[1][95], 1'b0);
    chkv("even_ready_rise", rise[1], 110);
    chk("odd_parity_bit", 2, smp[2][95], 1'b1);
    chkv("odd_ready_rise", rise[2], 110);
    chk("d7_bit7_is_stop", 4, smp[4][85], 1'b1);
    chkv("d7_ready_rise", rise[4], 90);

    // Back-to-back 0x00 then 0xFF with two stop bits, tdata churned while busy.
    rise[3]   = -1;
    tvalid[3] = 1'b1;
    tdata[3]  = 8'h00;
    cyc();
    tdata[3] = 8'hC3;
    for (int k = 1; k <= 240; k++) begin
      cyc();
      smp[3][k] = tx_w[3];
      if (k > 111 && rise[3] < 0 && rdy_w[3]) rise[3] = k;
      if (k == 110) chk("b2b_ready_up", 3, rdy_w[3], 1'b1);
      if (k == 105) tdata[3] = 8'hFF;
      if (k == 111) tvalid[3] = 1'b0;
    end
    for (int b = 1; b <= 8; b++) got8[b - 1] = smp[3][10 * b + 5];
    chkv("b2b_first_byte", int'(got8), 32'h00);
    first_fall = -1;
    for (int k = 101; k <= 240; k++) begin
      if (first_fall < 0 && smp[3][k] == 1'b0) first_fall = k;
    end
    chkv("b2b_second_start", first_fall, 112);
    for (int b = 1; b <= 8; b++) got8[b - 1] = smp[3][111 + 10 * b + 5];
    chkv("b2b_second_byte", int'(got8), 32'hFF);
    chkv("b2b_second_rise", rise[3], 221);

    // Reset during data bit 3 of 0x96, then a clean 0x3C.
    tvalid[0] = 1'b1;
    tdata[0]  = 8'h96;
    cyc();
    tvalid[0] = 1'b0;
    repeat (45) cyc();
    chk("mid_bit3_low", 0, tx_w[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 0, tx_w[0], 1'b1);
    chk("mid_rst_tready", 0, rdy_w[0], 1'b0);
    chk("mid_rst_busy", 0, busy_w[0], 1'b0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_rel_tready", 0, rdy_w[0], 1'b1);
    tvalid[0] = 1'b1;
    tdata[0]  = 8'h3C;
    cyc();
    tvalid[0] = 1'b0;
    rise[0]   = -1;
    for (int k = 1; k <= 105; k++) begin
      cyc();
      smp[0][k] = tx_w[0];
      if (rise[0] < 0 && rdy_w[0]) rise[0] = k;
    end
    for (int b = 1; b <= 8; b++) got8[b - 1] = smp[0][10 * b + 5];
    chkv("post_rst_byte", int'(got8), 32'h3C);
    chkv("post_rst_rise", rise[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
